// File: rtl/roic_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : roic_frame_sequencer
// Description : Frame timing FSM for the ROIC (fsync, setup, integration,
//               scan wait, blanking). Optional macro SCAN_TIMEOUT_EN adds a
//               WAIT_SCAN watchdog with a sticky timeout_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module roic_frame_sequencer #(
  parameter int INTG_W       = 16,
  parameter int SCAN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              master_rst,
  input  logic              start,
  input  logic              run,
  input  logic [INTG_W-1:0] cfg_intg_len,
  input  logic [INTG_W-1:0] cfg_blank_len,
  input  logic              scan_done,
  output logic              fsync,
  output logic              intg,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [2:0]        state
`ifdef SCAN_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FSYNC     = 3'd1,
    S_SETUP     = 3'd2,
    S_INTG      = 3'd3,
    S_WAIT_SCAN = 3'd4,
    S_BLANK     = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_fsync;
  logic                r_intg;
  logic                r_busy;
  logic [15:0]         r_frame_cnt;
  logic [INTG_W-1:0]   r_intg_len;
  logic [INTG_W-1:0]   r_blank_len;
  logic [INTG_W-1:0]   r_cnt;

  logic                w_timeout;
  logic                w_scan_exit;
  logic                w_frame_end;
  logic [INTG_W-1:0]   w_intg_load;

`ifdef SCAN_TIMEOUT_EN
  localparam int c_TO_W = (SCAN_TIMEOUT > 1) ? $clog2(SCAN_TIMEOUT) : 1;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                r_timeout_err;

  assign w_timeout   = (r_state == S_WAIT_SCAN) && !scan_done &&
                       (r_to_cnt == c_TO_W'(SCAN_TIMEOUT - 1));
  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
`endif

  // A zero integration length still yields one integration cycle.
  assign w_intg_load = (r_intg_len == '0) ? '0 : (r_intg_len - INTG_W'(1));
  assign w_scan_exit = (r_state == S_WAIT_SCAN) && (scan_done || w_timeout);
  assign w_frame_end = (w_scan_exit && (r_blank_len == '0)) ||
                       ((r_state == S_BLANK) && (r_cnt == '0));

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_state       <= S_IDLE;
      r_fsync       <= 1'b0;
      r_intg        <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_intg_len    <= '0;
      r_blank_len   <= '0;
      r_cnt         <= '0;
`ifdef SCAN_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start || run) begin
            r_state     <= S_FSYNC;
            r_fsync     <= 1'b1;
            r_busy      <= 1'b1;
            r_intg_len  <= cfg_intg_len;
            r_blank_len <= cfg_blank_len;
`ifdef SCAN_TIMEOUT_EN
            if (start) r_timeout_err <= 1'b0;
`endif
          end
        end
        S_FSYNC: begin
          r_state <= S_SETUP;
          r_fsync <= 1'b0;
        end
        S_SETUP: begin
          r_state <= S_INTG;
          r_intg  <= 1'b1;
          r_cnt   <= w_intg_load;
        end
        S_INTG: begin
          if (r_cnt == '0) begin
            r_state <= S_WAIT_SCAN;
            r_intg  <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end else begin
            r_cnt <= r_cnt - INTG_W'(1);
          end
        end
        S_WAIT_SCAN: begin
          if (scan_done) r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef SCAN_TIMEOUT_EN
          else r_to_cnt <= r_to_cnt + c_TO_W'(1);
          if (w_timeout) r_timeout_err <= 1'b1;
`endif
          if (w_scan_exit && (r_blank_len != '0)) begin
            r_state <= S_BLANK;
            r_cnt   <= r_blank_len - INTG_W'(1);
          end
        end
        S_BLANK: begin
          if (r_cnt != '0) r_cnt <= r_cnt - INTG_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      // End-of-frame decision shared by WAIT_SCAN (no blanking) and BLANK.
      if (w_frame_end) begin
        if (run) begin
          r_state     <= S_FSYNC;
          r_fsync     <= 1'b1;
          r_intg_len  <= cfg_intg_len;
          r_blank_len <= cfg_blank_len;
        end else begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign fsync     = r_fsync;
  assign intg      = r_intg;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_roic_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_roic_frame_sequencer
// Description : Directed self-checking bench for roic_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roic_frame_sequencer;

  logic        clk = 1'b0;
  logic        master_rst;
  logic        start;
  logic        run;
  logic [15:0] cfg_intg_len;
  logic [15:0] cfg_blank_len;
  logic        scan_done;
  logic        fsync;
  logic        intg;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [2:0]  state;
`ifdef SCAN_TIMEOUT_EN
  logic        timeout_err;
  logic        te_log [0:255];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_overlap = 0;

  // Log index k = cycle following clock edge k-1.
  logic [2:0]  st_log [0:255];
  logic        fs_log [0:255];
  logic        ig_log [0:255];
  logic        bz_log [0:255];
  logic [15:0] fc_log [0:255];

  always #5 clk = ~clk;

  roic_frame_sequencer #(
    .INTG_W       (16),
    .SCAN_TIMEOUT (64)
  ) dut (
    .clk           (clk),
    .master_rst    (master_rst),
    .start         (start),
    .run           (run),
    .cfg_intg_len  (cfg_intg_len),
    .cfg_blank_len (cfg_blank_len),
    .scan_done     (scan_done),
    .fsync         (fsync),
    .intg          (intg),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .state         (state)
`ifdef SCAN_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  always @(negedge clk) if (fsync && intg) n_overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_scan(input int e, input int f, input int p);
    if (f <= 0) return 1'b0;
    if (p == 0) return e == f;
    return (e >= f) && (((e - f) % p) == 0);
  endfunction

  function automatic int cnt_intg(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(ig_log[k]);
    return s;
  endfunction

  function automatic int cnt_fsync(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(fs_log[k]);
    return s;
  endfunction

  // Called at a negedge with inputs for edge 0 already set.
  task automatic run_frame(input int n, input int scan_first, input int scan_period,
                           input int run_off, input int chg_at, input logic [15:0] chg_val);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      @(negedge clk);
      st_log[j+1] = state;
      fs_log[j+1] = fsync;
      ig_log[j+1] = intg;
      bz_log[j+1] = busy;
      fc_log[j+1] = frame_cnt;
`ifdef SCAN_TIMEOUT_EN
      te_log[j+1] = timeout_err;
`endif
      start     = 1'b0;
      scan_done = is_scan(j + 1, scan_first, scan_period);
      if (run_off >= 0 && j + 1 > run_off) run = 1'b0;
      if (chg_at >= 0 && j + 1 >= chg_at) cfg_intg_len = chg_val;
    end
    scan_done = 1'b0;
  endtask

  initial begin
    master_rst    = 1'b1;
    start         = 1'b0;
    run           = 1'b0;
    cfg_intg_len  = 16'd0;
    cfg_blank_len = 16'd0;
    scan_done     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fsync", 32'(fsync), 32'd0);
    check("rst_intg", 32'(intg), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);
    master_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);

    // Single-shot frame: intg 10, blank 4, scan_done sampled at edge 50.
    cfg_intg_len  = 16'd10;
    cfg_blank_len = 16'd4;
    start         = 1'b1;
    run_frame(60, 50, 0, -1, -1, 16'd0);
    check("t1_fsync_c1", 32'(fs_log[1]), 32'd1);
    check("t1_fsync_cnt", 32'(cnt_fsync(1, 60)), 32'd1);
    check("t1_intg_c2", 32'(ig_log[2]), 32'd0);
    check("t1_intg_c3", 32'(ig_log[3]), 32'd1);
    check("t1_intg_c12", 32'(ig_log[12]), 32'd1);
    check("t1_intg_c13", 32'(ig_log[13]), 32'd0);
    check("t1_intg_cnt", 32'(cnt_intg(1, 60)), 32'd10);
    check("t1_wait_c13", 32'(st_log[13]), 32'd4);
    check("t1_fcnt_c50", 32'(fc_log[50]), 32'd0);
    check("t1_fcnt_c51", 32'(fc_log[51]), 32'd1);
    check("t1_blank_c51", 32'(st_log[51]), 32'd5);
    check("t1_blank_c54", 32'(st_log[54]), 32'd5);
    check("t1_busy_c54", 32'(bz_log[54]), 32'd1);
    check("t1_idle_c55", 32'(st_log[55]), 32'd0);
    check("t1_busy_c55", 32'(bz_log[55]), 32'd0);

    // Continuous frames, intg 0 -> 1 cycle, no blanking; run drops mid frame 4.
    master_rst = 1'b1;
    @(negedge clk);
    master_rst    = 1'b0;
    cfg_intg_len  = 16'd0;
    cfg_blank_len = 16'd0;
    run           = 1'b1;
    run_frame(120, 23, 23, 75, -1, 16'd0);
    check("t2_fsync_c1", 32'(fs_log[1]), 32'd1);
    check("t2_fsync_c24", 32'(fs_log[24]), 32'd1);
    check("t2_fsync_c47", 32'(fs_log[47]), 32'd1);
    check("t2_fsync_c70", 32'(fs_log[70]), 32'd1);
    check("t2_fsync_cnt", 32'(cnt_fsync(1, 120)), 32'd4);
    check("t2_intg_c3", 32'(ig_log[3]), 32'd1);
    check("t2_intg_c26", 32'(ig_log[26]), 32'd1);
    check("t2_intg_cnt", 32'(cnt_intg(1, 120)), 32'd4);
    check("t2_fcnt_c24", 32'(fc_log[24]), 32'd1);
    check("t2_fcnt_c47", 32'(fc_log[47]), 32'd2);
    check("t2_fcnt_c70", 32'(fc_log[70]), 32'd3);
    check("t2_fcnt_c93", 32'(fc_log[93]), 32'd4);
    check("t2_idle_c93", 32'(st_log[93]), 32'd0);
    check("t2_fcnt_idle", 32'(fc_log[120]), 32'd4);
    check("t2_idle_c120", 32'(st_log[120]), 32'd0);

    // intg length changed to 3 during the first frame's integration.
    cfg_intg_len  = 16'd10;
    cfg_blank_len = 16'd2;
    run           = 1'b1;
    run_frame(35, 14, 9, 18, 5, 16'd3);
    check("t3_intg_f1", 32'(cnt_intg(1, 16)), 32'd10);
    check("t3_intg_c12", 32'(ig_log[12]), 32'd1);
    check("t3_intg_c13", 32'(ig_log[13]), 32'd0);
    check("t3_fsync_c17", 32'(fs_log[17]), 32'd1);
    check("t3_intg_f2", 32'(cnt_intg(17, 35)), 32'd3);
    check("t3_intg_c19", 32'(ig_log[19]), 32'd1);
    check("t3_intg_c21", 32'(ig_log[21]), 32'd1);
    check("t3_intg_c22", 32'(ig_log[22]), 32'd0);
    check("t3_fcnt_c15", 32'(fc_log[15]), 32'd5);
    check("t3_idle_c26", 32'(st_log[26]), 32'd0);
    check("t3_fcnt_end", 32'(fc_log[35]), 32'd6);

    // Reset mid-integration; start and scan_done while in INTG are ignored.
    cfg_intg_len  = 16'd10;
    cfg_blank_len = 16'd0;
    start         = 1'b1;
    run_frame(5, -1, 0, -1, -1, 16'd0);
    start     = 1'b1;
    scan_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    scan_done = 1'b0;
    check("t4_state_intg", 32'(state), 32'd3);
    check("t4_intg_on", 32'(intg), 32'd1);
    check("t4_fcnt_hold", 32'(frame_cnt), 32'd6);
    #2 master_rst = 1'b1;
    #1;
    check("t4_rst_intg", 32'(intg), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_state", 32'(state), 32'd0);
    check("t4_rst_fcnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    master_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_post_idle", 32'(state), 32'd0);
    check("t4_post_busy", 32'(busy), 32'd0);

    // frame_cnt wrap 0xFFFF -> 0x0000.
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    cfg_intg_len  = 16'd0;
    cfg_blank_len = 16'd0;
    start         = 1'b1;
    run_frame(6, 4, 0, -1, -1, 16'd0);
    check("t5_wait_c4", 32'(st_log[4]), 32'd4);
    check("t5_fcnt_pre", 32'(fc_log[4]), 32'h0000FFFF);
    check("t5_fcnt_wrap", 32'(fc_log[5]), 32'd0);
    check("t5_idle_c5", 32'(st_log[5]), 32'd0);

`ifdef SCAN_TIMEOUT_EN
    // No scan_done: watchdog fires after 64 WAIT_SCAN cycles (c4..c67).
    cfg_intg_len  = 16'd0;
    cfg_blank_len = 16'd2;
    start         = 1'b1;
    run_frame(72, -1, 0, -1, -1, 16'd0);
    check("t6_te_c67", 32'(te_log[67]), 32'd0);
    check("t6_wait_c67", 32'(st_log[67]), 32'd4);
    check("t6_te_c68", 32'(te_log[68]), 32'd1);
    check("t6_blank_c68", 32'(st_log[68]), 32'd5);
    check("t6_fcnt", 32'(fc_log[70]), 32'd0);
    check("t6_idle_c70", 32'(st_log[70]), 32'd0);
    check("t6_te_sticky", 32'(te_log[72]), 32'd1);
    start = 1'b1;
    run_frame(2, -1, 0, -1, -1, 16'd0);
    check("t6_te_clear", 32'(te_log[1]), 32'd0);
    check("t6_restart", 32'(st_log[1]), 32'd1);
    master_rst = 1'b1;
    @(negedge clk);
    master_rst = 1'b0;
`endif

    check("no_overlap", 32'(n_overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/roic_frame_sequencer.md
ROIC_FRAME_SEQUENCER -- requirements
Module: roic_frame_sequencer

Interface
REQ-001 Parameter INTG_W, default 16: width of integration and blanking length fields.
REQ-002 Parameter SCAN_TIMEOUT, default 1024: maximum WAIT_SCAN cycles before timeout (used only with SCAN_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 master_rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-shot frame request, sampled only in IDLE.
REQ-006 run  input  1  level; continuous frames while high.
REQ-007 cfg_intg_len  input  INTG_W  integration length in cycles, 0 treated as 1.
REQ-008 cfg_blank_len  input  INTG_W  blanking cycles between scan completion and next frame.
REQ-009 scan_done  input  1  one-cycle pulse from the 16x16 matrix scanner, end of readout.
REQ-010 fsync  output  1  frame sync pulse to scanner, registered.
REQ-011 intg  output  1  integration window to scanner, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_cnt  output  16  count of completed frames.
REQ-014 state  output  3  current state encoding, for debug.
REQ-015 timeout_err  output  1  sticky scan-timeout flag (present only with SCAN_TIMEOUT_EN).

Function
REQ-016 States SHALL be IDLE=0, FSYNC=1, SETUP=2, INTG=3, WAIT_SCAN=4, BLANK=5.
REQ-017 IDLE -> FSYNC when start or run sampled high; else remain IDLE.
REQ-018 FSYNC lasts exactly 1 cycle with fsync=1; cfg_intg_len and cfg_blank_len SHALL be latched on entry to FSYNC and held for the whole frame.
REQ-019 SETUP lasts exactly 1 cycle with fsync=0, intg=0.
REQ-020 INTG SHALL hold intg=1 for exactly max(latched intg_len,1) cycles, then -> WAIT_SCAN.
REQ-021 WAIT_SCAN -> BLANK on the cycle scan_done is sampled high; frame_cnt SHALL increment at that edge, wrapping 0xFFFF -> 0x0000.
REQ-022 scan_done in any state other than WAIT_SCAN SHALL be ignored.
REQ-023 BLANK lasts latched blank_len cycles (0 = no BLANK cycle, i.e. WAIT_SCAN exits directly to the next-state decision); then -> FSYNC if run high, else -> IDLE.
REQ-024 start while busy SHALL be ignored; run deasserted mid-frame SHALL let the current frame finish, then IDLE.
REQ-025 Latency: start sampled at edge N -> fsync=1 during cycle N+1, intg first high during cycle N+3.
REQ-026 fsync and intg SHALL never be high in the same cycle.

Reset
REQ-027 master_rst high SHALL immediately force state=IDLE, fsync=0, intg=0, busy=0, frame_cnt=0, timeout_err=0, internal counters=0, regardless of current state.
REQ-028 After master_rst falls, the first frame SHALL start only on a subsequent start or run sample.

Configuration
REQ-029 Macro SCAN_TIMEOUT_EN: when defined, a cycle counter runs in WAIT_SCAN; reaching SCAN_TIMEOUT cycles without scan_done SHALL set timeout_err, go to BLANK, and not increment frame_cnt; timeout_err clears only on reset or an accepted start.
REQ-030 Without SCAN_TIMEOUT_EN, WAIT_SCAN SHALL wait indefinitely, no timeout counter is built, and timeout_err SHALL be absent from the port list.

Verification
REQ-031 Reset released, start pulse at cycle 0, cfg_intg_len=10, cfg_blank_len=4, scan_done at cycle 50 -> fsync high cycle 1 only, intg high cycles 3-12, frame_cnt=1 after scan_done, IDLE after 4 BLANK cycles.
REQ-032 run held high, cfg_intg_len=0, cfg_blank_len=0, scan_done 20 cycles after each WAIT_SCAN entry -> intg 1 cycle wide, back-to-back frames, frame_cnt increments each frame.
REQ-033 cfg_intg_len changed 10 -> 3 during INTG -> current intg stays 10 cycles; next frame intg 3 cycles.
REQ-034 master_rst asserted mid-INTG -> intg and busy drop immediately, frame_cnt=0, state=0; start pulse during busy and scan_done during INTG have no effect.
REQ-035 SCAN_TIMEOUT_EN defined, SCAN_TIMEOUT=64, no scan_done -> timeout_err=1 after 64 WAIT_SCAN cycles, frame_cnt unchanged, next start clears timeout_err.
REQ-036 frame_cnt preloaded to 0xFFFF via 65535 short frames (or force), one more frame -> frame_cnt=0x0000.
